// File: rtl/logic_reduce_pkg.sv
// Shared op encodings and tree sizing helpers for the logic_reduce_pipe slice.
package logic_reduce_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int num_levels(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  // Element count entering tree level lvl (each level halves, rounding up).
  function automatic int level_elems(input int n, input int lvl);
    int m;
    m = n;
    for (int i = 0; i < lvl; i++) m = (m + 1) / 2;
    return m;
  endfunction

endpackage

// File: rtl/logic_reduce_stage.sv
// One reduction tree level: pairwise op on M lanes-wide elements into ceil(M/2), registered.
// One cycle latency; holds all state when en_i is low.
module logic_reduce_stage
  import logic_reduce_pkg::*;
#(
  parameter int  WIDTH    = 4,
  parameter int  M        = 2,
  parameter bit  INV_XNOR = 1'b0,
  localparam int MO       = (M + 1) / 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic                vld_i,
  input  logic [1:0]          op_i,
  input  logic [M*WIDTH-1:0]  dat_i,
  output logic                vld_o,
  output logic [1:0]          op_o,
  output logic [MO*WIDTH-1:0] dat_o
);

  logic [MO*WIDTH-1:0] red;
  logic [MO*WIDTH-1:0] dat_d;
  logic [MO*WIDTH-1:0] dat_q;
  logic                vld_q;
  logic [1:0]          op_q;

  for (genvar p = 0; p < MO; p++) begin : g_pair
    if (2 * p + 1 < M) begin : g_op
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      assign a = dat_i[2*p*WIDTH +: WIDTH];
      assign b = dat_i[(2*p+1)*WIDTH +: WIDTH];
      // XNOR reduces as XOR; the single inversion happens only at the last level.
      assign red[p*WIDTH +: WIDTH] = (op_i == OP_AND) ? (a & b) :
                                     (op_i == OP_OR)  ? (a | b) : (a ^ b);
    end else begin : g_pass
      assign red[p*WIDTH +: WIDTH] = dat_i[2*p*WIDTH +: WIDTH];
    end
  end

  assign dat_d = (INV_XNOR && (op_i == OP_XNOR)) ? ~red : red;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q <= 1'b0;
      op_q  <= OP_AND;
      dat_q <= '0;
    end else if (en_i) begin
      vld_q <= vld_i;
      op_q  <= op_i;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign op_o  = op_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/logic_reduce_pipe.sv
// Pipelined N-operand AND/OR/XOR/XNOR lane reduction; LOGIC_REDUCE_ACCUM_EN adds I_last packet folding.
// Latency L=max(1,clog2(N)) (L+1 with accumulator); global stall when O_valid & ~O_ready, I_ready=~O_valid|O_ready.
module logic_reduce_pipe
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N*WIDTH-1:0] I,
  input  logic [1:0]         OP,
  input  logic               I_valid,
  output logic               I_ready,
`ifdef LOGIC_REDUCE_ACCUM_EN
  input  logic               I_last,
`endif
  output logic [WIDTH-1:0]   O,
  output logic               O_valid,
  input  logic               O_ready
);

  localparam int L = num_levels(N);
`ifdef LOGIC_REDUCE_ACCUM_EN
  localparam bit TREE_INV = 1'b0;
`else
  localparam bit TREE_INV = 1'b1;
`endif

  logic             en;
  logic             vld_c [0:L];
  logic [1:0]       op_c  [0:L];
  logic [WIDTH-1:0] tree_dat;

  assign en       = ~O_valid | O_ready;
  assign I_ready  = en;
  assign vld_c[0] = I_valid;
  assign op_c[0]  = OP;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int M  = level_elems(N, k);
    localparam int MO = (M + 1) / 2;
    logic [M*WIDTH-1:0]  din;
    logic [MO*WIDTH-1:0] dat;
    if (k == 0) begin : g_head
      assign din = I;
    end else begin : g_body
      assign din = g_lvl[k-1].dat;
    end
    logic_reduce_stage #(
      .WIDTH   (WIDTH),
      .M       (M),
      .INV_XNOR(TREE_INV && (k == L - 1))
    ) u_stage (
      .clk_i  (CLK),
      .reset_i(RESET),
      .en_i   (en),
      .vld_i  (vld_c[k]),
      .op_i   (op_c[k]),
      .dat_i  (din),
      .vld_o  (vld_c[k+1]),
      .op_o   (op_c[k+1]),
      .dat_o  (dat)
    );
  end

  assign tree_dat = g_lvl[L-1].dat;

`ifdef LOGIC_REDUCE_ACCUM_EN
  logic             last_q [0:L-1];
  logic [WIDTH-1:0] acc_q, acc_d, out_q, out_d, fold;
  logic [1:0]       acc_op_q, acc_op_d, fold_op;
  logic             act_q, act_d, out_vld_q, out_vld_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < L; k++) last_q[k] <= 1'b0;
    end else if (en) begin
      last_q[0] <= I_last;
      for (int k = 1; k < L; k++) last_q[k] <= last_q[k-1];
    end
  end

  // The first beat of a packet latches the op; later beats fold with it.
  always_comb begin
    fold_op = act_q ? acc_op_q : op_c[L];
    if (!act_q)                  fold = tree_dat;
    else if (fold_op == OP_AND)  fold = acc_q & tree_dat;
    else if (fold_op == OP_OR)   fold = acc_q | tree_dat;
    else                         fold = acc_q ^ tree_dat;
    acc_d     = acc_q;
    acc_op_d  = acc_op_q;
    act_d     = act_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (en) begin
      out_vld_d = 1'b0;
      if (vld_c[L]) begin
        if (last_q[L-1]) begin
          out_d     = (fold_op == OP_XNOR) ? ~fold : fold;
          out_vld_d = 1'b1;
          acc_d     = '0;
          acc_op_d  = OP_AND;
          act_d     = 1'b0;
        end else begin
          acc_d    = fold;
          acc_op_d = fold_op;
          act_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q     <= '0;
      acc_op_q  <= OP_AND;
      act_q     <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_op_q  <= acc_op_d;
      act_q     <= act_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign O       = out_q;
  assign O_valid = out_vld_q;
`else
  assign O       = tree_dat;
  assign O_valid = vld_c[L];
`endif

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Scoreboard bench: five instances of logic_reduce_pipe at different WIDTH/N, directed vectors.
module tb_logic_reduce_pipe;
  import logic_reduce_pkg::*;

`ifdef LOGIC_REDUCE_ACCUM_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  a_i;  logic [1:0] a_op; logic a_iv, a_ir, a_ov, a_or; logic [3:0] a_o;
  logic [39:0] b_i;  logic [1:0] b_op; logic b_iv, b_ir, b_ov, b_or; logic [7:0] b_o;
  logic [23:0] c_i;  logic [1:0] c_op; logic c_iv, c_ir, c_ov, c_or; logic [7:0] c_o;
  logic [3:0]  d_i;  logic [1:0] d_op; logic d_iv, d_ir, d_ov, d_or; logic [3:0] d_o;
  logic [15:0] e_i;  logic [1:0] e_op; logic e_iv, e_ir, e_ov, e_or; logic [7:0] e_o;
`ifdef LOGIC_REDUCE_ACCUM_EN
  logic e_last;
`endif

  logic [7:0] qa[$], qb[$], qc[$], qd[$], qe[$];

  logic_reduce_pipe #(.WIDTH(4), .N(2)) u_a (
    .CLK(clk), .RESET(rst), .I(a_i), .OP(a_op), .I_valid(a_iv), .I_ready(a_ir),
`ifdef LOGIC_REDUCE_ACCUM_EN
    .I_last(1'b1),
`endif
    .O(a_o), .O_valid(a_ov), .O_ready(a_or));

  logic_reduce_pipe #(.WIDTH(8), .N(5)) u_b (
    .CLK(clk), .RESET(rst), .I(b_i), .OP(b_op), .I_valid(b_iv), .I_ready(b_ir),
`ifdef LOGIC_REDUCE_ACCUM_EN
    .I_last(1'b1),
`endif
    .O(b_o), .O_valid(b_ov), .O_ready(b_or));

  logic_reduce_pipe #(.WIDTH(8), .N(3)) u_c (
    .CLK(clk), .RESET(rst), .I(c_i), .OP(c_op), .I_valid(c_iv), .I_ready(c_ir),
`ifdef LOGIC_REDUCE_ACCUM_EN
    .I_last(1'b1),
`endif
    .O(c_o), .O_valid(c_ov), .O_ready(c_or));

  logic_reduce_pipe #(.WIDTH(4), .N(1)) u_d (
    .CLK(clk), .RESET(rst), .I(d_i), .OP(d_op), .I_valid(d_iv), .I_ready(d_ir),
`ifdef LOGIC_REDUCE_ACCUM_EN
    .I_last(1'b1),
`endif
    .O(d_o), .O_valid(d_ov), .O_ready(d_or));

  logic_reduce_pipe #(.WIDTH(8), .N(2)) u_e (
    .CLK(clk), .RESET(rst), .I(e_i), .OP(e_op), .I_valid(e_iv), .I_ready(e_ir),
`ifdef LOGIC_REDUCE_ACCUM_EN
    .I_last(e_last),
`endif
    .O(e_o), .O_valid(e_ov), .O_ready(e_or));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  function automatic logic ov_of(input int d);
    case (d)
      0:       return a_ov;
      1:       return b_ov;
      2:       return c_ov;
      3:       return d_ov;
      default: return e_ov;
    endcase
  endfunction

  task automatic push(input int d, input logic [7:0] v);
    case (d)
      0:       qa.push_back(v);
      1:       qb.push_back(v);
      2:       qc.push_back(v);
      3:       qd.push_back(v);
      default: qe.push_back(v);
    endcase
  endtask

  task automatic pop_chk(input string name, input int d, input logic [7:0] got);
    logic [7:0] exp;
    bit         have;
    have = 1'b0;
    exp  = '0;
    case (d)
      0:       if (qa.size() > 0) begin exp = qa.pop_front(); have = 1'b1; end
      1:       if (qb.size() > 0) begin exp = qb.pop_front(); have = 1'b1; end
      2:       if (qc.size() > 0) begin exp = qc.pop_front(); have = 1'b1; end
      3:       if (qd.size() > 0) begin exp = qd.pop_front(); have = 1'b1; end
      default: if (qe.size() > 0) begin exp = qe.pop_front(); have = 1'b1; end
    endcase
    if (have) check(name, {24'h0, got}, {24'h0, exp});
    else begin
      n_chk++;
      $display("FAIL %s: unexpected output %0h, required no output", name, got);
    end
  endtask

  // Monitor: every accepted output beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_ov && a_or) pop_chk("A out", 0, {4'h0, a_o});
      if (b_ov && b_or) pop_chk("B out", 1, b_o);
      if (c_ov && c_or) pop_chk("C out", 2, c_o);
      if (d_ov && d_or) pop_chk("D out", 3, {4'h0, d_o});
      if (e_ov && e_or) pop_chk("E out", 4, e_o);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d, input logic [39:0] ops, input logic [1:0] op,
                      input logic [7:0] exp, input bit want);
    logic acc;
    acc = 1'b0;
    case (d)
      0:       begin a_i = ops[7:0];  a_op = op; a_iv = 1'b1; end
      1:       begin b_i = ops;       b_op = op; b_iv = 1'b1; end
      2:       begin c_i = ops[23:0]; c_op = op; c_iv = 1'b1; end
      3:       begin d_i = ops[3:0];  d_op = op; d_iv = 1'b1; end
      default: begin e_i = ops[15:0]; e_op = op; e_iv = 1'b1; end
    endcase
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      case (d)
        0:       acc = a_ir;
        1:       acc = b_ir;
        2:       acc = c_ir;
        3:       acc = d_ir;
        default: acc = e_ir;
      endcase
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_chk++;
      $display("FAIL accept dut%0d: I_ready stayed 0, required 1 within 64 cycles", d);
    end else if (want) push(d, exp);
    case (d)
      0:       a_iv = 1'b0;
      1:       b_iv = 1'b0;
      2:       c_iv = 1'b0;
      3:       d_iv = 1'b0;
      default: e_iv = 1'b0;
    endcase
  endtask

  task automatic lat_chk(input string name, input int d, input int lat);
    for (int k = 0; k < lat; k++) begin
      check(name, {31'h0, ov_of(d)}, {31'h0, (k == lat - 1)});
      if (k < lat - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    repeat (10) @(posedge clk);
    #1;
  endtask

  logic [39:0] sv [6] = '{40'hFF_F0_F3_FE_F7, 40'h01_00_10_00_80, 40'hFF_0F_F0_AA_00,
                          40'h10_08_04_02_01, 40'h3C_3C_FF_7E_BD, 40'h00_00_00_00_00};
  logic [1:0]  so [6] = '{OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_AND, OP_OR};
  logic [7:0]  se [6] = '{8'hF0, 8'h91, 8'hAA, 8'hE0, 8'h3C, 8'h00};
  logic [7:0]  ce [3] = '{8'h00, 8'hFF, 8'hC3};

  initial begin
    rst = 1'b1;
    a_i = '0; b_i = '0; c_i = '0; d_i = '0; e_i = '0;
    a_op = OP_AND; b_op = OP_AND; c_op = OP_AND; d_op = OP_AND; e_op = OP_AND;
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0; d_iv = 1'b0; e_iv = 1'b0;
    a_or = 1'b1; b_or = 1'b1; c_or = 1'b1; d_or = 1'b1; e_or = 1'b1;
`ifdef LOGIC_REDUCE_ACCUM_EN
    e_last = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset B O_valid", {31'h0, b_ov}, 32'h0);
    check("reset B O", {24'h0, b_o}, 32'h0);
    check("reset B I_ready", {31'h0, b_ir}, 32'h1);
    check("reset A O", {28'h0, a_o}, 32'h0);
    rst = 1'b0;

    // N=2, W=4: AND {A,C} -> 8 one cycle later, then the other ops back to back.
    send(0, 40'hAC, OP_AND, 8'h08, 1'b1);
    lat_chk("A latency", 0, 1 + XL);
    send(0, 40'hAC, OP_OR,   8'h0E, 1'b1);
    send(0, 40'hAC, OP_XOR,  8'h06, 1'b1);
    send(0, 40'hAC, OP_XNOR, 8'h09, 1'b1);
    drain();

    // N=5: odd element passes through two levels.
    send(1, 40'h10_08_04_02_01, OP_XOR, 8'h1F, 1'b1);
    lat_chk("B latency", 1, 3 + XL);
    drain();
    send(1, 40'h10_08_04_02_01, OP_XNOR, 8'hE0, 1'b1);
    lat_chk("B latency xnor", 1, 3 + XL);
    drain();

    // N=3: op changes every beat, results on consecutive cycles.
    send(2, 40'h0F_3C_F0, OP_AND, ce[0], 1'b1);
    send(2, 40'h0F_3C_F0, OP_OR,  ce[1], 1'b1);
    send(2, 40'h0F_3C_F0, OP_XOR, ce[2], 1'b1);
    for (int j = 1 - XL; j < 3; j++) begin
      check("C consecutive valid", {31'h0, c_ov}, 32'h1);
      check("C consecutive data", {24'h0, c_o}, {24'h0, ce[j]});
      @(posedge clk); #1;
    end
    drain();

    // N=1: single register stage, XNOR inverts.
    send(3, 40'h5, OP_OR,   8'h05, 1'b1);
    send(3, 40'h5, OP_XNOR, 8'h0A, 1'b1);
    send(3, 40'h3, OP_AND,  8'h03, 1'b1);
    send(3, 40'hC, OP_XOR,  8'h0C, 1'b1);
    drain();

    send(4, 40'hF00F, OP_XOR,  8'hFF, 1'b1);
    send(4, 40'hF00F, OP_XNOR, 8'h00, 1'b1);
    send(4, 40'h0FFF, OP_AND,  8'h0F, 1'b1);
    drain();

`ifdef LOGIC_REDUCE_ACCUM_EN
    e_last = 1'b0; send(4, 40'h0201, OP_OR, 8'h00, 1'b0);
                   send(4, 40'h0804, OP_OR, 8'h00, 1'b0);
    e_last = 1'b1; send(4, 40'h2010, OP_OR, 8'h3F, 1'b1);
    e_last = 1'b0; send(4, 40'hFFC0, OP_AND, 8'h00, 1'b0);
    e_last = 1'b1; send(4, 40'hC3FF, OP_AND, 8'hC0, 1'b1);
    drain();
`endif

    // Six-beat stream with a four-cycle consumer stall in the middle.
    fork
      begin
        for (int s = 0; s < 6; s++) send(1, sv[s], so[s], se[s], 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        b_or = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("stall O stable", {24'h0, b_o}, {24'h0, se[1-XL]});
          check("stall O_valid", {31'h0, b_ov}, 32'h1);
          check("stall I_ready", {31'h0, b_ir}, 32'h0);
          @(posedge clk); #1;
        end
        b_or = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight discards them.
    send(1, 40'h10_08_04_02_01, OP_XOR, 8'h1F, 1'b1);
    send(1, 40'h10_08_04_02_01, OP_OR,  8'h1F, 1'b1);
    rst = 1'b1;
    qb.delete();
    @(posedge clk); #1;
    check("mid reset O_valid", {31'h0, b_ov}, 32'h0);
    check("mid reset O", {24'h0, b_o}, 32'h0);
    check("mid reset I_ready", {31'h0, b_ir}, 32'h1);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("post reset no stale", {31'h0, b_ov}, 32'h0);
    end
    drain();

    check("A scoreboard empty", qa.size(), 32'h0);
    check("B scoreboard empty", qb.size(), 32'h0);
    check("C scoreboard empty", qc.size(), 32'h0);
    check("D scoreboard empty", qd.size(), 32'h0);
    check("E scoreboard empty", qe.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/logic_reduce_pipe.md
# logic_reduce_pipe

Pipelined, parametrised bitwise reduction of N operands of WIDTH bits each, with run-time operation select (AND/OR/XOR/XNOR) and valid/ready flow control. Successor to the fixed two-input, four-bit combinational AND array: same lane-wise bit semantics, generalised to N inputs, selectable op, registered tree stages and backpressure. It sits between operand producers and any datapath consumer that needs a registered mask or parity word at full clock rate.

## Interface

Parameters:
- WIDTH, 4, bits per operand and result lane count
- N, 2, number of operands; N ≥ 1

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- I  input  N*WIDTH  packed operands; operand k is I[k*WIDTH +: WIDTH]
- OP  input  2  op select: 00 AND, 01 OR, 10 XOR, 11 XNOR
- I_valid  input  1  beat on I/OP is valid
- I_ready  output  1  block accepts beat this cycle
- O  output  WIDTH  reduction result
- O_valid  output  1  O holds a valid result
- O_ready  input  1  consumer accepts O this cycle
- I_last  input  1  end of accumulation packet; present only with LOGIC_REDUCE_ACCUM_EN

## Operation

- Bit j of O = OP applied across bit j of all N operands; lanes independent.
- Tree of L = max(1, clog2(N)) levels; each level pairs adjacent elements (0,1),(2,3)…; an unpaired last element passes through unchanged.
- Levels use AND, OR, or XOR (XOR for both XOR and XNOR); XNOR inversion applied once, at the final level only.
- OP carried with data through every level; OP may change every beat.
- Each level has a register plus valid bit. Global advance enable: en = ~O_valid | O_ready. When en = 0 all levels hold.
- I_ready = en. Beat accepted when I_valid & I_ready.
- Bubbles (I_valid = 0 while en = 1) propagate as invalid stages; no beat dropped or duplicated.
- N = 1: O = I (XNOR: ~I) after one register stage.
- Reset: all stage valids 0, all stage data 0, O = 0, O_valid = 0, I_ready = 1 in the first cycle after reset. Reset mid-operation discards all in-flight beats.

## Timing

- Latency: L cycles from accepted beat to O_valid, with O_ready held high.
- Throughput: one beat per cycle while O_ready = 1.
- O_valid & ~O_ready: O, O_valid stable until accepted; I_ready = 0 same cycle (combinational from O_valid, O_ready).
- Simultaneous accept at input and output in one cycle is legal and required for full rate.

## Configuration

- LOGIC_REDUCE_ACCUM_EN defined: I_last port present; output accumulator after tree. Per-beat tree results fold into accumulator with the OP of the first beat of the packet (later OP values ignored until packet end). O_valid asserted only for the beat carrying I_last; O = folded result (XNOR inversion applied at emit). Accumulator cleared on emit and on RESET. Single-beat packet (I_last on first beat) equals non-accum result. Latency L+1.
- Not defined: no I_last port, no accumulator; each beat independent, latency L.

## Structure

- Package logic_reduce_pkg: op encoding constants (OP_AND, OP_OR, OP_XOR, OP_XNOR), clog2 function, level-count computation.
- Sub-module logic_reduce_stage: one tree level (pairwise op on M elements → ceil(M/2), pass-through of odd element) plus its data/op/valid register and enable; instantiated L times by generate.

## Test plan

- WIDTH=4, N=2, OP=AND, I = {4'hA, 4'hC} (operand1=A, operand0=C), O_ready=1 -> O=4'h8, O_valid one cycle later.
- WIDTH=8, N=5, OP=XOR, operands 01,02,04,08,10 -> O=8'h1F after 3 cycles; same with OP=XNOR -> 8'hE0.
- N=3, back-to-back OP sequence AND/OR/XOR on operands F0,3C,0F -> 00, FF, C3 on consecutive cycles, order preserved.
- Stream 6 beats, hold O_ready=0 for 4 cycles mid-stream -> O stable, I_ready=0 during stall, all 6 results delivered in order, none duplicated.
- Assert RESET with 2 beats in flight -> next cycle O_valid=0, O=0, I_ready=1; no stale result emitted afterward.
- With LOGIC_REDUCE_ACCUM_EN, N=2, OR: beats {01,02},{04,08},{10,20} with I_last on third -> single O=8'h3F; next packet AND starts from cleared accumulator.
